gcm_block_scheduler: RTL and testbench
======================================

# gcm_block_scheduler

Sequencer that turns one GCM instance descriptor (AAD length, plaintext length, IV) into an ordered stream of per-block dispatch tags for the four parallel AES encryption workers. It sits between the frame ingress logic and the worker pipelines. It replaces free-running per-worker counting with a single in-order source of block index, counter block, worker id and phase code, and it applies back-pressure per worker.

## Interface
Parameters:
- N_WORKERS, 4, number of parallel encryption workers; power of two
- MAX_BLOCKS, 100000, largest legal total block count per instance

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse: descriptor inputs are valid this cycle
- i_aad_bits  in  [0:63]  AAD length in bits
- i_pt_bits  in  [0:63]  plaintext length in bits
- i_iv  in  [0:95]  96-bit IV
- i_worker_ready  in  [0:N_WORKERS-1]  per-worker ready; bit k belongs to worker k
- o_valid  out  1  dispatch tag valid
- o_worker_id  out  [0:1]  target worker, equal to block_idx mod N_WORKERS
- o_block_idx  out  [0:16]  block index within the instance, 0-based; AAD blocks first
- o_counter  out  [0:127]  counter block, {iv, 32-bit ctr}
- o_phase  out  [0:2]  phase code, see Operation
- o_busy  out  1  instance in progress
- o_done  out  1  one-cycle pulse after the final dispatch
- o_error  out  1  one-cycle pulse when a descriptor is rejected

## Operation
- Derived counts: aad_blocks = i_aad_bits>>7; pt_blocks = i_pt_bits>>7; total = aad_blocks + pt_blocks. The low 7 bits of each length are ignored. Sums use 65-bit arithmetic, so there is no wrap.
- Rejection: if total > MAX_BLOCKS, pulse o_error, stay in IDLE and issue no dispatch.
- FSM states: IDLE, AAD, TEXT, FIN.
  - IDLE, i_start, accepted descriptor: go to AAD if aad_blocks > 0. Otherwise go to TEXT if pt_blocks > 0. Otherwise go to FIN.
  - AAD to TEXT: after dispatch of block aad_blocks-1, if pt_blocks > 0. Otherwise go to FIN.
  - TEXT to FIN: after dispatch of block total-1.
  - FIN to IDLE: unconditional. o_done pulses while in FIN.
- Phase codes:
  - 010: every AAD block.
  - 000: first text block.
  - 001: middle text block.
  - 011: last text block, when pt_blocks ≥ 2.
  - 111: sole text block, when pt_blocks == 1.
  - 100: whenever o_valid = 0.
- Counter field:
  - AAD blocks: 0.
  - Text block j (j = block_idx − aad_blocks): j+2, so the first text block gets ctr = 2. J0 = ctr 1 is reserved for the tag stage.
- Handshake:
  - A dispatch happens on a cycle with o_valid & i_worker_ready[o_worker_id].
  - While the target worker is not ready, all tag outputs hold stable. Strict order: a later block never bypasses a stalled block.
- Restart: i_start while o_busy = 1 is ignored. No error, and the descriptor is dropped.
- o_busy = 1 in AAD, TEXT and FIN.

## Timing
- Reset: FSM returns to IDLE and all registers clear. The reset values are:
  - o_valid, o_busy, o_done, o_error, o_block_idx, o_counter, o_worker_id: all 0.
  - o_phase: 100.
- Reset wins over i_start in the same cycle. Reset mid-instance abandons it with no o_done.
- Latency: descriptor registered on the i_start edge, and the first o_valid is high the following cycle.
- Throughput: one dispatch per cycle when the target worker is ready.
- After the final dispatch edge, o_valid falls and o_done is high for exactly that next cycle. o_busy falls with the cycle after o_done.
- o_error is asserted the cycle after the rejected i_start.
- Zero-length descriptor: o_done the cycle after i_start, with no o_valid.
- A new i_start is accepted in the cycle after FIN, when o_busy = 0.

## Structure
- Shared package gcm_pkg holds:
  - phase localparams: PH_AAD=010, PH_FIRST=000, PH_MID=001, PH_LAST=011, PH_ONLY=111, PH_IDLE=100;
  - MAX_BLOCKS;
  - the FSM state enum type;
  - the CTR_TEXT_BASE=2 constant.
- One natural sub-module, gcm_phase_decode: combinational mapping of (block_idx, aad_blocks, total) to a phase code. It is reusable by the tag stage.

## Test plan
- aad=256 bits, pt=512 bits, all ready: 6 dispatches on consecutive cycles.
  - idx 0..5, worker 0,1,2,3,0,1; phases 010,010,000,001,001,011; ctr 0,0,2,3,4,5.
  - o_done one cycle after idx 5.
- aad=0, pt=128 bits: single dispatch, phase 111, ctr 2, worker 0; then o_done.
- aad=384, pt=0: 3 dispatches, all phase 010; then o_done, with no text phases.
- Stall: aad=0, pt=1024 bits, drop i_worker_ready[2] for 5 cycles while idx 2 is presented.
  - idx 2 outputs are held for all 5 cycles; idx 3 is not issued until the stall clears.
  - Order is preserved.
- Oversized descriptor (pt=(MAX_BLOCKS+1)*128): o_error one cycle later, no o_valid, o_busy stays 0.
- Hazards:
  - i_start during a busy instance is ignored.
  - rst asserted mid-TEXT gives all outputs at reset values the next cycle, with no o_done.
  - A fresh i_start then runs cleanly from idx 0.

Source files
------------

// File: rtl/gcm_pkg.sv
// gcm_pkg: phase codes, block limits and FSM state type shared by the GCM block scheduler and tag stage
package gcm_pkg;
   localparam logic [2:0] PH_AAD   = 3'b010;
   localparam logic [2:0] PH_FIRST = 3'b000;
   localparam logic [2:0] PH_MID   = 3'b001;
   localparam logic [2:0] PH_LAST  = 3'b011;
   localparam logic [2:0] PH_ONLY  = 3'b111;
   localparam logic [2:0] PH_IDLE  = 3'b100;
   localparam int MAX_BLOCKS = 100000;
   localparam int IDX_W = 17;
   localparam logic [31:0] CTR_TEXT_BASE = 32'd2;
   typedef enum logic [1:0] {S_IDLE, S_AAD, S_TEXT, S_FIN} state_t;
endpackage

// File: rtl/gcm_block_scheduler_if.sv
// gcm_block_scheduler_if: descriptor, per-worker ready and dispatch tag bundle
//   i_start/i_aad_bits/i_pt_bits/i_iv : descriptor, valid on i_start pulse
//   i_worker_ready                    : per-worker back-pressure, bit k = worker k
//   o_valid/o_worker_id/o_block_idx/o_counter/o_phase : dispatch tag
//   o_busy/o_done/o_error             : instance status
interface gcm_block_scheduler_if #(parameter int N_WORKERS = 4);
   import gcm_pkg::*;
   localparam int ID_W = $clog2(N_WORKERS);
   logic                 i_start;
   logic [63:0]          i_aad_bits;
   logic [63:0]          i_pt_bits;
   logic [95:0]          i_iv;
   logic [N_WORKERS-1:0] i_worker_ready;
   logic                 o_valid;
   logic [ID_W-1:0]      o_worker_id;
   logic [IDX_W-1:0]     o_block_idx;
   logic [127:0]         o_counter;
   logic [2:0]           o_phase;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_error;
   modport master (
      output i_start, i_aad_bits, i_pt_bits, i_iv, i_worker_ready,
      input  o_valid, o_worker_id, o_block_idx, o_counter, o_phase, o_busy, o_done, o_error
   );
   modport slave (
      input  i_start, i_aad_bits, i_pt_bits, i_iv, i_worker_ready,
      output o_valid, o_worker_id, o_block_idx, o_counter, o_phase, o_busy, o_done, o_error
   );
endinterface

// File: rtl/gcm_phase_decode.sv
// gcm_phase_decode: maps (valid, block_idx, aad_blocks, total) to the dispatch phase code
//   i_valid, i_block_idx, i_aad_blocks, i_total -> o_phase
module gcm_phase_decode
   import gcm_pkg::*;
(
   input  logic             i_valid,
   input  logic [IDX_W-1:0] i_block_idx,
   input  logic [IDX_W-1:0] i_aad_blocks,
   input  logic [IDX_W-1:0] i_total,
   output logic [2:0]       o_phase
);
   assign o_phase = !i_valid                                 ? PH_IDLE  :
                    i_block_idx < i_aad_blocks               ? PH_AAD   :
                    i_total - i_aad_blocks == IDX_W'(1)      ? PH_ONLY  :
                    i_block_idx == i_aad_blocks              ? PH_FIRST :
                    i_block_idx == i_total - IDX_W'(1)       ? PH_LAST  : PH_MID;
endmodule

// File: rtl/gcm_block_scheduler.sv
// gcm_block_scheduler: turns one GCM descriptor into an in-order stream of per-block worker dispatch tags
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of gcm_block_scheduler_if (descriptor in, dispatch tag and status out)
module gcm_block_scheduler #(
   parameter int N_WORKERS  = 4,
   parameter int MAX_BLOCKS = gcm_pkg::MAX_BLOCKS
) (
   input logic                  clk,
   input logic                  rst,
   gcm_block_scheduler_if.slave bus
);
   import gcm_pkg::*;
   localparam int ID_W = $clog2(N_WORKERS);
   state_t           r_state, w_next;
   logic [IDX_W-1:0] r_idx, r_aad, r_total;
   logic [95:0]      r_iv;
   logic             r_error;
   logic [56:0]      w_aad_blk, w_pt_blk;
   logic [64:0]      w_sum;
   logic             w_start_idle, w_over, w_accept, w_valid, w_fire;
   logic [31:0]      w_ctr;
   logic [2:0]       w_phase;
   assign w_aad_blk = bus.i_aad_bits[63:7];
   assign w_pt_blk  = bus.i_pt_bits[63:7];
   // 65-bit sum so two huge lengths can never wrap into an accepted count
   assign w_sum        = {8'd0, w_aad_blk} + {8'd0, w_pt_blk};
   assign w_start_idle = r_state == S_IDLE && bus.i_start;
   assign w_over       = w_sum > 65'(MAX_BLOCKS);
   assign w_accept     = w_start_idle && !w_over;
   assign w_valid      = r_state == S_AAD || r_state == S_TEXT;
   assign w_fire       = w_valid && bus.i_worker_ready[r_idx[ID_W-1:0]];
   assign w_ctr        = {{(32-IDX_W){1'b0}}, r_idx - r_aad} + CTR_TEXT_BASE;
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_aad_blk != 0 ? S_AAD : w_pt_blk != 0 ? S_TEXT : S_FIN;
         S_AAD:   if (w_fire && r_idx == r_aad - IDX_W'(1)) w_next = r_total != r_aad ? S_TEXT : S_FIN;
         S_TEXT:  if (w_fire && r_idx == r_total - IDX_W'(1)) w_next = S_FIN;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= '0;
         r_aad   <= '0;
         r_total <= '0;
         r_iv    <= '0;
         r_error <= 1'b0;
      end else begin
         r_error <= w_start_idle && w_over;
         if (w_accept) begin
            r_aad   <= w_aad_blk[IDX_W-1:0];
            r_total <= w_sum[IDX_W-1:0];
            r_iv    <= bus.i_iv;
            r_idx   <= '0;
         end else if (r_state == S_FIN) r_idx <= '0;
         else if (w_fire) r_idx <= r_idx + IDX_W'(1);
      end
   end
   gcm_phase_decode u_phase (
      .i_valid      (w_valid),
      .i_block_idx  (r_idx),
      .i_aad_blocks (r_aad),
      .i_total      (r_total),
      .o_phase      (w_phase)
   );
   assign bus.o_valid     = w_valid;
   assign bus.o_worker_id = r_idx[ID_W-1:0];
   assign bus.o_block_idx = r_idx;
   assign bus.o_counter   = r_state == S_TEXT ? {r_iv, w_ctr} : '0;
   assign bus.o_phase     = w_phase;
   assign bus.o_busy      = r_state != S_IDLE;
   assign bus.o_done      = r_state == S_FIN;
   assign bus.o_error     = r_error;
endmodule

// File: tb/tb_gcm_block_scheduler.sv
// tb_gcm_block_scheduler: directed and randomized checks of the GCM block scheduler against a tag-list model
module tb_gcm_block_scheduler;
   import gcm_pkg::*;
   localparam int NW = 4;
   typedef struct {
      int           idx;
      int           wk;
      logic [127:0] ctr;
      logic [2:0]   ph;
   } tag_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   gcm_block_scheduler_if #(.N_WORKERS(NW)) bus ();
   gcm_block_scheduler #(.N_WORKERS(NW), .MAX_BLOCKS(MAX_BLOCKS)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, bus.o_valid, 0);
      chk({tag, "_busy"}, bus.o_busy, 0);
      chk({tag, "_done"}, bus.o_done, 0);
      chk({tag, "_error"}, bus.o_error, 0);
      chk({tag, "_idx"}, bus.o_block_idx, 0);
      chk({tag, "_ctr"}, bus.o_counter, 0);
      chk({tag, "_wk"}, bus.o_worker_id, 0);
      chk({tag, "_phase"}, bus.o_phase, 3'b100);
   endtask

   task automatic start(input logic [63:0] a, input logic [63:0] p, input logic [95:0] iv);
      bus.i_start = 1'b1;
      bus.i_aad_bits = a;
      bus.i_pt_bits = p;
      bus.i_iv = iv;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
   endtask

   task automatic run(input logic [63:0] a, input logic [63:0] p, input logic [95:0] iv,
                      input bit rnd, input int stall_idx, input bit poke);
      tag_t q[$];
      int na, np, cyc, seen_stall, stall_left;
      na = int'(a >> 7);
      np = int'(p >> 7);
      cyc = 0;
      seen_stall = 0;
      stall_left = 5;
      for (int i = 0; i < na + np; i++) begin
         tag_t t;
         t.idx = i;
         t.wk = i % NW;
         t.ctr = i < na ? 128'd0 : {iv, 32'(i - na + 2)};
         t.ph = i < na ? 3'b010 : np == 1 ? 3'b111 : i == na ? 3'b000 : i == na + np - 1 ? 3'b011 : 3'b001;
         q.push_back(t);
      end
      bus.i_worker_ready = '1;
      start(a, p, iv);
      while (q.size() > 0 && cyc < 40 * (na + np) + 20) begin
         logic [NW-1:0] rdy;
         rdy = rnd ? NW'($urandom) : '1;
         if (q[0].idx == stall_idx) seen_stall++;
         if (q[0].idx == stall_idx && stall_left > 0) begin
            rdy[q[0].wk] = 1'b0;
            stall_left--;
         end
         if (poke && cyc == 1) begin
            bus.i_start = 1'b1;
            bus.i_aad_bits = 64'd128;
            bus.i_pt_bits = 64'd0;
         end else bus.i_start = 1'b0;
         bus.i_worker_ready = rdy;
         @(negedge clk);
         chk("valid", bus.o_valid, 1);
         chk("idx", bus.o_block_idx, 128'(q[0].idx));
         chk("worker", bus.o_worker_id, 128'(q[0].wk));
         chk("ctr", bus.o_counter, q[0].ctr);
         chk("phase", bus.o_phase, q[0].ph);
         chk("busy", bus.o_busy, 1);
         chk("done_early", bus.o_done, 0);
         if (rdy[q[0].wk]) void'(q.pop_front());
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.i_start = 1'b0;
      chk("timeout_left", 128'(q.size()), 0);
      if (!rnd && stall_idx < 0) chk("consecutive", 128'(cyc), 128'(na + np));
      if (stall_idx >= 0) chk("stall_presented", 128'(seen_stall), 6);
      @(negedge clk);
      chk("fin_done", bus.o_done, 1);
      chk("fin_valid", bus.o_valid, 0);
      chk("fin_phase", bus.o_phase, 3'b100);
      chk("fin_busy", bus.o_busy, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("post_done", bus.o_done, 0);
      chk("post_busy", bus.o_busy, 0);
      chk("post_valid", bus.o_valid, 0);
      bus.i_worker_ready = '1;
   endtask

   task automatic reject(input logic [63:0] a, input logic [63:0] p);
      start(a, p, 96'h0);
      @(negedge clk);
      chk("rej_error", bus.o_error, 1);
      chk("rej_valid", bus.o_valid, 0);
      chk("rej_busy", bus.o_busy, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rej_error_pulse", bus.o_error, 0);
      chk("rej_valid2", bus.o_valid, 0);
      chk("rej_busy2", bus.o_busy, 0);
   endtask

   initial begin
      bus.i_start = 1'b0;
      bus.i_aad_bits = '0;
      bus.i_pt_bits = '0;
      bus.i_iv = '0;
      bus.i_worker_ready = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      run(64'd256, 64'd512, 96'hCAFE_0000_1111_2222_3333_4444, 1'b0, -1, 1'b0);
      run(64'd0, 64'd128, 96'h0123_4567_89AB_CDEF_0011_2233, 1'b0, -1, 1'b0);
      run(64'd384, 64'd0, 96'hFFFF_0000_FFFF_0000_FFFF_0000, 1'b0, -1, 1'b0);
      run(64'd0, 64'd1024, 96'hA5A5_A5A5_5A5A_5A5A_1234_5678, 1'b0, 2, 1'b0);
      reject(64'd0, 64'(MAX_BLOCKS + 1) << 7);
      reject('1, '1);
      run(64'd0, 64'd127, 96'h1, 1'b0, -1, 1'b0);
      for (int k = 0; k < 5; k++)
         run(64'($urandom_range(0, 5)) * 64'd128 + 64'($urandom_range(0, 127)),
             64'($urandom_range(0, 9)) * 64'd128 + 64'($urandom_range(0, 127)),
             {$urandom, $urandom, $urandom}, 1'b1, -1, k[0]);
      start(64'(MAX_BLOCKS - 1) << 7, 64'd133, 96'h5);
      @(negedge clk);
      chk("max_accept_valid", bus.o_valid, 1);
      chk("max_accept_error", bus.o_error, 0);
      chk("max_accept_phase", bus.o_phase, 3'b010);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start(64'd0, 64'd1024, 96'h77);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("midtext_idx", bus.o_block_idx, 2);
      chk("midtext_phase", bus.o_phase, 3'b001);
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk_reset("midreset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midreset_nodone", bus.o_done, 0);
      chk("midreset_idle", bus.o_busy, 0);
      run(64'd128, 64'd384, 96'hBEEF, 1'b0, -1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
